// File: rtl/m14k_ssram_sp_bw_core.sv
// Single-port synchronous SRAM with per-byte write enables and a one-cycle registered line read.
// The write word is replicated across every word of the line so one value can land in any subset of ways.
module m14k_ssram_sp_bw_core #(
    parameter int BYTES           = 384,
    parameter int BITS_PER_BYTE   = 24,
    parameter int BYTES_PER_WORD  = 1,
    parameter int WORDS_PER_LINE  = 2,
    parameter int LINE_IDX_SIZE   = 6,
    localparam int WORD_WIDTH     = BITS_PER_BYTE * BYTES_PER_WORD,
    localparam int BYTES_PER_LINE = BYTES_PER_WORD * WORDS_PER_LINE,
    localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE,
    localparam int DEPTH          = 2 ** LINE_IDX_SIZE
) (
    input  logic                      clk,
    input  logic                      greset_n,
    input  logic [LINE_IDX_SIZE-1:0]  line_idx,
    input  logic [BYTES_PER_LINE-1:0] wr_mask,
    input  logic                      rd_str,
    input  logic                      wr_str,
    input  logic [WORD_WIDTH-1:0]     wr_data,
    output logic [LINE_WIDTH-1:0]     rd_data
);

    // BYTES is nominal only; depth is set by LINE_IDX_SIZE.
    if (BYTES < 0) begin : g_bytes_nominal
    end

    logic [LINE_WIDTH-1:0] r_mem [DEPTH];
    logic [LINE_WIDTH-1:0] r_rd_data;
    logic [LINE_WIDTH-1:0] w_wr_line;

    // Broadcast the write word so byte b sees byte (b mod BYTES_PER_WORD) of wr_data.
    always_comb begin
        w_wr_line = {WORDS_PER_LINE{wr_data}};
    end

    // Array write: only the masked bytes of the addressed line change; no reset on contents.
    always @(posedge clk) begin
        if (wr_str) begin
            for (int b = 0; b < BYTES_PER_LINE; b++) begin
                if (wr_mask[b]) begin
                    r_mem[line_idx][b*BITS_PER_BYTE +: BITS_PER_BYTE] <= w_wr_line[b*BITS_PER_BYTE +: BITS_PER_BYTE];
                end
            end
        end
    end

    // Registered read; sampling the array before the write update gives read-old on collision.
    always_ff @(posedge clk or negedge greset_n) begin
        if (!greset_n) begin
            r_rd_data <= {LINE_WIDTH{1'b0}};
        end else if (rd_str) begin
            r_rd_data <= r_mem[line_idx];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign rd_data = r_rd_data;

    // Zero-time backdoor read of a full line.
    task automatic Read(input int unsigned idx, output logic [LINE_WIDTH-1:0] data);
        logic [LINE_IDX_SIZE-1:0] w_idx;
        w_idx = idx[LINE_IDX_SIZE-1:0];
        data  = r_mem[w_idx];
    endtask

    // Zero-time backdoor overwrite of one word; the index wraps and out-of-range words are ignored.
    task automatic Write(input int unsigned idx, input int unsigned word_idx, input logic [WORD_WIDTH-1:0] data);
        logic [LINE_IDX_SIZE-1:0] w_idx;
        w_idx = idx[LINE_IDX_SIZE-1:0];
        if (word_idx < WORDS_PER_LINE) begin
            r_mem[w_idx][word_idx*WORD_WIDTH +: WORD_WIDTH] <= data;
        end
    endtask

endmodule

// File: tb/tb_m14k_ssram_sp_bw_core.sv
// Self-checking bench for m14k_ssram_sp_bw_core: a line model feeds a scoreboard of expected read data.
module tb_m14k_ssram_sp_bw_core;

    logic        clk;
    logic        greset_n;
    logic [5:0]  line_idx;
    logic [1:0]  wr_mask;
    logic        rd_str;
    logic        wr_str;
    logic [23:0] wr_data;
    logic [47:0] rd_data;

    int n_cmp;
    int n_err;

    logic [47:0] model [64];
    logic [47:0] sb [$];

    m14k_ssram_sp_bw_core dut (
        .clk      (clk),
        .greset_n (greset_n),
        .line_idx (line_idx),
        .wr_mask  (wr_mask),
        .rd_str   (rd_str),
        .wr_str   (wr_str),
        .wr_data  (wr_data),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive at negedge, update model/scoreboard, return 1 time unit after the edge.
    task automatic drive(input logic rd, input logic wr, input logic [5:0] idx,
                         input logic [1:0] mask, input logic [23:0] data);
        @(negedge clk);
        rd_str   = rd;
        wr_str   = wr;
        line_idx = idx;
        wr_mask  = mask;
        wr_data  = data;
        if (rd) sb.push_back(model[idx]);
        if (wr) begin
            if (mask[0]) model[idx][23:0]  = data;
            if (mask[1]) model[idx][47:24] = data;
        end
        @(posedge clk);
        #1;
        rd_str = 1'b0;
        wr_str = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] exp;
        greset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected %h", rd_data, 48'h0);
        end
        @(negedge clk);
        greset_n = 1'b1;
        drive(1'b0, 1'b0, 6'd10, 2'b00, 24'h0);
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_release_hold: got %h expected %h", rd_data, 48'h0);
        end
        drive(1'b0, 1'b1, 6'd10, 2'b11, 24'hC0FFEE);
        drive(1'b1, 1'b0, 6'd10, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL reset_preload: got %h expected %h", rd_data, exp);
        end
        #2;
        greset_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", rd_data, 48'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", rd_data, 48'h0);
        end
        @(negedge clk);
        greset_n = 1'b1;
        drive(1'b0, 1'b0, 6'd10, 2'b00, 24'h0);
        n_cmp++;
        if (rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL reset_stays_zero: got %h expected %h", rd_data, 48'h0);
        end
        drive(1'b1, 1'b0, 6'd10, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL reset_contents_kept: got %h expected %h", rd_data, exp);
        end
    endtask

    task automatic test_full_write();
        logic [47:0] exp;
        drive(1'b0, 1'b1, 6'd5, 2'b11, 24'hABCDEF);
        drive(1'b1, 1'b0, 6'd5, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL full_write: got %h expected %h", rd_data, exp);
        end
    endtask

    task automatic test_masked_write();
        logic [47:0] exp;
        drive(1'b0, 1'b1, 6'd5, 2'b10, 24'h123456);
        drive(1'b1, 1'b0, 6'd5, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL masked_write_upper: got %h expected %h", rd_data, exp);
        end
        drive(1'b0, 1'b1, 6'd5, 2'b00, 24'hFFFFFF);
        drive(1'b1, 1'b0, 6'd5, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL masked_write_none: got %h expected %h", rd_data, exp);
        end
        drive(1'b0, 1'b1, 6'd6, 2'b01, 24'h5A5A5A);
        drive(1'b0, 1'b1, 6'd6, 2'b10, 24'hA5A5A5);
        drive(1'b1, 1'b0, 6'd6, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL masked_write_lanes: got %h expected %h", rd_data, exp);
        end
    endtask

    task automatic test_read_hold();
        logic [47:0] exp;
        drive(1'b0, 1'b1, 6'd7, 2'b11, 24'h777777);
        drive(1'b1, 1'b0, 6'd5, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL read_line5: got %h expected %h", rd_data, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 6'd7, 2'b00, 24'h0);
            n_cmp++;
            if (rd_data !== model[5]) begin
                n_err++;
                $display("FAIL read_hold_%0d: got %h expected %h", i, rd_data, model[5]);
            end
        end
    endtask

    task automatic test_collision();
        logic [47:0] exp;
        drive(1'b0, 1'b1, 6'd3, 2'b11, 24'h000000);
        drive(1'b1, 1'b1, 6'd3, 2'b11, 24'h000001);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL collision_read_old: got %h expected %h", rd_data, exp);
        end
        drive(1'b1, 1'b0, 6'd3, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL collision_new_visible: got %h expected %h", rd_data, exp);
        end
    endtask

    task automatic test_backdoor();
        logic [47:0] exp;
        logic [47:0] line;
        logic [47:0] held;
        drive(1'b0, 1'b1, 6'd63, 2'b11, 24'h636363);
        drive(1'b0, 1'b1, 6'd0,  2'b11, 24'h000AAA);
        drive(1'b0, 1'b1, 6'd9,  2'b11, 24'h090909);
        drive(1'b1, 1'b0, 6'd9,  2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL backdoor_pre_read: got %h expected %h", rd_data, exp);
        end
        held = exp;
        dut.Write(63, 1, 24'hFACE00);
        dut.Write(64, 0, 24'h111111);
        dut.Write(9, 2, 24'hDEAD00);
        model[63][47:24] = 24'hFACE00;
        model[0][23:0]   = 24'h111111;
        #1;
        dut.Read(63, line);
        n_cmp++;
        if (line !== model[63]) begin
            n_err++;
            $display("FAIL backdoor_read63: got %h expected %h", line, model[63]);
        end
        n_cmp++;
        if (rd_data !== held) begin
            n_err++;
            $display("FAIL backdoor_no_rd_change: got %h expected %h", rd_data, held);
        end
        drive(1'b1, 1'b0, 6'd0, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL backdoor_wrap_idx0: got %h expected %h", rd_data, exp);
        end
        drive(1'b1, 1'b0, 6'd9, 2'b00, 24'h0);
        exp = sb.pop_front();
        n_cmp++;
        if (rd_data !== exp) begin
            n_err++;
            $display("FAIL backdoor_word_ignored: got %h expected %h", rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp;
        logic        rd;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 6'(i), 2'b11, 24'($urandom));
        end
        for (int i = 0; i < 80; i++) begin
            rd = ($urandom_range(0, 3) != 0);
            drive(rd, 1'($urandom), 6'($urandom), 2'($urandom), 24'($urandom));
            if (rd) begin
                exp = sb.pop_front();
                n_cmp++;
                if (rd_data !== exp) begin
                    n_err++;
                    $display("FAIL back_to_back_%0d: got %h expected %h", i, rd_data, exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        greset_n = 1'b0;
        rd_str   = 1'b0;
        wr_str   = 1'b0;
        line_idx = 6'd0;
        wr_mask  = 2'b00;
        wr_data  = 24'h0;
        for (int i = 0; i < 64; i++) model[i] = 48'h0;
        test_reset();
        test_full_write();
        test_masked_write();
        test_read_hold();
        test_collision();
        test_backdoor();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
